// File: rtl/fp_mult_sched_pkg.sv
// fp_mult_sched_pkg: shared types and status bit positions for the multiplier scheduler.
package fp_mult_sched_pkg;
    localparam int ST_OVF     = 7;
    localparam int ST_UDF     = 6;
    localparam int ST_ZERO    = 5;
    localparam int ST_INF     = 4;
    localparam int ST_NAN     = 3;
    localparam int ST_TINY    = 2;
    localparam int ST_HUGE    = 1;
    localparam int ST_INEXACT = 0;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} slot_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at/after ptr.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] id,
    output logic         any
);
    logic [W-1:0] j;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        j     = '0;
        // scan from the far end so the nearest requester after ptr is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                id  = j;
                any = 1'b1;
            end
        end
        grant[id] = any;
    end
endmodule

// File: rtl/fp_mult_scheduler.sv
// fp_mult_scheduler: round-robin sharing of one pipelined FP multiplier, results routed back by tag.
module fp_mult_scheduler
    import fp_mult_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ*3-1:0]   req_rnd,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [N_REQ*32-1:0]  rsp_z,
    output logic [N_REQ*8-1:0]   rsp_status,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    output logic [2:0]           mult_rnd,
    input  logic [31:0]          mult_z,
    input  logic [7:0]           mult_status,
    output logic [7:0]           sticky_status,
    input  logic                 clr_sticky,
    output logic                 busy
);
    localparam int PW = $clog2(N_REQ);

    slot_state_e      slot [N_REQ];
    tag_t             tags [LATENCY+1];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] grant;
    logic             gnt;
    logic             tag_busy;

    always_comb begin
        tag_busy  = 1'b0;
        cand      = '0;
        rsp_valid = '0;
        for (int k = 0; k <= LATENCY; k++) tag_busy = tag_busy | tags[k].valid;
        for (int i = 0; i < N_REQ; i++) begin
            cand[i]      = req_valid[i] && slot[i] == IDLE;
            rsp_valid[i] = slot[i] == DONE;
        end
    end

    rr_arbiter #(.N(N_REQ), .W(PW)) u_arb (
        .req   (cand),
        .ptr   (ptr),
        .grant (grant),
        .id    (win),
        .any   (gnt)
    );

    assign req_ready = rst ? '0 : grant;
    assign busy      = tag_busy || |rsp_valid;

    // tags[0] shadows the operand register, tags[1..LATENCY] shadow the multiplier stages
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            mult_a        <= '0;
            mult_b        <= '0;
            mult_rnd      <= '0;
            rsp_z         <= '0;
            rsp_status    <= '0;
            sticky_status <= '0;
            for (int i = 0; i < N_REQ; i++) slot[i] <= IDLE;
            for (int k = 0; k <= LATENCY; k++) tags[k] <= '0;
        end else begin
            tags[0] <= {gnt, ID_W'(win)};
            for (int k = 1; k <= LATENCY; k++) tags[k] <= tags[k-1];
            if (gnt) begin
                mult_a   <= req_a[32*win +: 32];
                mult_b   <= req_b[32*win +: 32];
                mult_rnd <= req_rnd[3*win +: 3];
                ptr      <= win == PW'(N_REQ - 1) ? '0 : win + 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i])
                    slot[i] <= INFLIGHT;
                else if (tags[LATENCY].valid && tags[LATENCY].id == ID_W'(i)) begin
                    slot[i]              <= DONE;
                    rsp_z[32*i +: 32]    <= mult_z;
                    rsp_status[8*i +: 8] <= mult_status;
                end else if (slot[i] == DONE && rsp_ready[i])
                    slot[i] <= IDLE;
            end
            sticky_status <= (clr_sticky ? 8'h00 : sticky_status) | (tags[LATENCY].valid ? mult_status : 8'h00);
        end
    end
endmodule

// File: tb/tb_fp_mult_scheduler.sv
// tb_fp_mult_scheduler: directed bench with a behavioural multiplier and per-requester result scoreboard.
module tb_fp_mult_scheduler;
    import fp_mult_sched_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    typedef struct {
        logic [31:0] z;
        logic [7:0]  st;
        int          due;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } g_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_a, req_b, rsp_z;
    logic [N*3-1:0]  req_rnd;
    logic [N*8-1:0]  rsp_status;
    logic [31:0]     mult_a, mult_b, mult_z;
    logic [2:0]      mult_rnd;
    logic [7:0]      mult_status, sticky_status;
    logic            clr_sticky, busy;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          hs_cnt [N] = '{default: 0};
    exp_t        sb [N][$];
    g_t          glog [$];
    logic [N-1:0] pv = '0;
    logic [39:0] mp [LAT] = '{default: '0};
    logic [39:0] mon_r;
    exp_t        mon_e;
    logic [31:0] held;
    int          h0, h1;

    fp_mult_scheduler #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_rnd       (req_rnd),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_z         (rsp_z),
        .rsp_status    (rsp_status),
        .mult_a        (mult_a),
        .mult_b        (mult_b),
        .mult_rnd      (mult_rnd),
        .mult_z        (mult_z),
        .mult_status   (mult_status),
        .sticky_status (sticky_status),
        .clr_sticky    (clr_sticky),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // truncating single-precision multiply, enough to give distinct results and flags
    function automatic logic [39:0] fmul(logic [31:0] a, logic [31:0] b);
        logic s, az, bz, ai, bi, lost;
        logic [47:0] p;
        logic [22:0] m;
        int e;
        s  = a[31] ^ b[31];
        az = a[30:0] == 31'h0;
        bz = b[30:0] == 31'h0;
        ai = a[30:0] == 31'h7F800000;
        bi = b[30:0] == 31'h7F800000;
        if ((az && bi) || (ai && bz)) return {32'h7FC00000, 8'h08};
        if (az || bz) return {s, 31'h0, 8'h20};
        if (ai || bi) return {s, 31'h7F800000, 8'h10};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24]; lost = |p[23:0]; e++;
        end else begin
            m = p[45:23]; lost = |p[22:0];
        end
        if (e >= 255) return {s, 31'h7F800000, 8'h93};
        if (e <= 0) return {s, 31'h0, 8'h65};
        return {s, e[7:0], m, 7'b0, lost};
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mp[0] <= fmul(mult_a, mult_b);
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end
    assign mult_z      = mp[LAT-1][39:8];
    assign mult_status = mp[LAT-1][7:0];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += sb[i].size();
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) pv = '0;
        else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_r     = fmul(req_a[32*i +: 32], req_b[32*i +: 32]);
                    mon_e.z   = mon_r[39:8];
                    mon_e.st  = mon_r[7:0];
                    mon_e.due = cyc + LAT + 2;
                    sb[i].push_back(mon_e);
                    hs_cnt[i]++;
                    glog.push_back('{i, cyc});
                end
                if (rsp_valid[i] && !pv[i]) begin
                    chk("rsp_expected", 64'(sb[i].size() > 0), 1);
                    if (sb[i].size() > 0) chk("latency", cyc, sb[i][0].due);
                end
                if (rsp_valid[i] && rsp_ready[i] && sb[i].size() > 0) begin
                    mon_e = sb[i].pop_front();
                    chk("rsp_z", rsp_z[32*i +: 32], mon_e.z);
                    chk("rsp_status", rsp_status[8*i +: 8], mon_e.st);
                end
            end
            chk("grant_onehot", $onehot0(req_ready), 1);
            pv = rsp_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [2:0] rnd);
        int n = 0;
        logic hs = 1'b0;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_rnd[3*i +: 3] = rnd;
        req_valid[i]      = 1'b1;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = req_ready[i];
            step();
            n++;
        end
        req_valid[i] = 1'b0;
        chk("issue_handshake", hs, 1);
    endtask

    task automatic wait_rsp(int i);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", rsp_valid[i], 1);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((busy || pending() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_scoreboard", pending(), 0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) sb[i].delete();
        glog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_rnd = '0;
        rsp_ready = '1; clr_sticky = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_rnd", mult_rnd, 0);
        chk("rst_sticky", sticky_status, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_rsp_status", rsp_status, 0);
        step();
        rst = 1'b0; req_valid = '0;

        rsp_ready[0] = 1'b0;
        issue(0, 32'h40000000, 32'h40400000, 3'd0);
        wait_rsp(0);
        chk("single_z", rsp_z[31:0], 32'h40C00000);
        chk("single_status", rsp_status[7:0], 8'h00);
        chk("single_busy_held", busy, 1);
        step();
        rsp_ready[0] = 1'b1;
        step();
        @(negedge clk);
        chk("single_busy_after", busy, 0);
        chk("single_rsp_valid_after", rsp_valid[0], 0);
        step();

        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h3F800000 + (i << 20);
            req_b[32*i +: 32] = 32'h40000000;
        end
        req_valid = '1;
        repeat (16) @(posedge clk);
        #1 req_valid = '0;
        drain();
        chk("fair_count", 64'(glog.size() >= 8), 1);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("fair_id", glog[k].id, k % 4);
        for (int k = 1; k < 4 && k < glog.size(); k++) chk("fair_consecutive", glog[k].cyc - glog[0].cyc, k);

        rsp_ready[2:1] = 2'b00;
        issue(1, 32'h3F800000, 32'h00000000, 3'd1);
        issue(2, 32'h7F800000, 32'h3F800000, 3'd2);
        wait_rsp(2);
        chk("route_valid1", rsp_valid[1], 1);
        chk("route_z1", rsp_z[63:32], 32'h00000000);
        chk("route_zero1", rsp_status[8+ST_ZERO], 1);
        chk("route_inf1", rsp_status[8+ST_INF], 0);
        chk("route_z2", rsp_z[95:64], 32'h7F800000);
        chk("route_inf2", rsp_status[16+ST_INF], 1);
        chk("route_zero2", rsp_status[16+ST_ZERO], 0);
        chk("route_others", {rsp_valid[3], rsp_valid[0]}, 2'b00);
        chk("route_mult_rnd", mult_rnd, 3'd2);
        step();
        rsp_ready = '1;
        drain();

        rsp_ready[0] = 1'b0;
        issue(0, 32'h40400000, 32'h40400000, 3'd0);
        wait_rsp(0);
        held = rsp_z[31:0];
        chk("bp_first_z", held, 32'h41100000);
        step();
        req_a[31:0] = 32'h40000000; req_b[31:0] = 32'h40000000; req_valid[0] = 1'b1;
        req_a[63:32] = 32'h3FC00000; req_b[63:32] = 32'h40000000; req_valid[1] = 1'b1;
        h1 = hs_cnt[1];
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready0", req_ready[0], 0);
            chk("bp_valid0", rsp_valid[0], 1);
            chk("bp_stable_z0", rsp_z[31:0], held);
        end
        chk("bp_others_progress", 64'(hs_cnt[1] > h1), 1);
        step();
        req_valid[1] = 1'b0;
        rsp_ready[0] = 1'b1;
        h0 = hs_cnt[0];
        for (int n = 0; n < 40 && hs_cnt[0] == h0; n++) step();
        req_valid[0] = 1'b0;
        chk("bp_resume0", 64'(hs_cnt[0] > h0), 1);
        drain();

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", sticky_status, 8'h00);
        step();
        issue(0, 32'h00000000, 32'h7F800000, 3'd0);
        issue(1, 32'h7F000000, 32'h7F000000, 3'd0);
        drain();
        @(negedge clk);
        chk("sticky_nan", sticky_status[ST_NAN], 1);
        chk("sticky_ovf", sticky_status[ST_OVF], 1);
        chk("sticky_both", sticky_status, 8'h9B);
        step();
        issue(2, 32'h00000000, 32'h3F800000, 3'd0);
        repeat (LAT) @(posedge clk);
        #1 clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr_capture", sticky_status, 8'h20);
        drain();

        rsp_ready[0] = 1'b0;
        issue(0, 32'h40000000, 32'h40000000, 3'd0);
        wait_rsp(0);
        step();
        issue(3, 32'h3F800000, 32'h40000000, 3'd0);
        step();
        rst = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        step();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) sb[i].delete();
        repeat (8) begin
            @(negedge clk);
            chk("midrst_rsp_valid", rsp_valid, 0);
            chk("midrst_busy", busy, 0);
        end
        chk("midrst_rsp_z", rsp_z, 0);
        chk("midrst_rsp_status", rsp_status, 0);
        chk("midrst_mult_a", mult_a, 0);
        chk("midrst_mult_b", mult_b, 0);
        chk("midrst_sticky", sticky_status, 0);
        step();
        issue(3, 32'h40000000, 32'h40400000, 3'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
